// File: rtl/shift_out_pkg.sv
// Shared types for the shift_out_reg serial transmitter: state encoding and
// the bit-counter width helper.
package shift_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold DATA_WIDTH-1 as its load value.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/shift_out_reg.sv
// Parallel-in, serial-out transmitter feeding the shift_in_reg deserializer.
// Optional macro SHIFT_OUT_STALL_EN adds i_STALL to pause a frame in flight.
module shift_out_reg
  import shift_out_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_VALID,
`ifdef SHIFT_OUT_STALL_EN
  input  logic                  i_STALL,
`endif
  output logic                  o_READY,
  output logic                  o_D,
  output logic                  o_EN,
  output logic                  o_BUSY,
  output logic                  o_DONE
);

  // state | meaning
  // IDLE  | waiting for a word, o_READY high
  // SHIFT | driving bits MSB-first with o_EN high
  // DONE  | one-cycle o_DONE pulse after the last bit

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  d_q,     d_d;
  logic                  en_q,    en_d;
  logic                  done_q,  done_d;
  logic                  stall;

`ifdef SHIFT_OUT_STALL_EN
  assign stall = i_STALL;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_VALID) begin
          shreg_d = i_DATA;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
          d_d     = i_DATA[DATA_WIDTH-1];
          en_d    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stall) begin
          // Hold everything; dropping o_EN pauses the receiver.
          en_d = 1'b0;
        end else if (cnt_q != '0) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          d_d     = shreg_q[DATA_WIDTH-2];
          cnt_d   = cnt_q - 1'b1;
          en_d    = 1'b1;
        end else begin
          d_d     = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        d_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign o_D     = d_q;
  assign o_EN    = en_q;
  assign o_DONE  = done_q;
  assign o_READY = (state_q == IDLE);
  assign o_BUSY  = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_shift_out_reg.sv
// Randomized and directed bench for shift_out_reg against a frame-timing model
// derived from the acceptance-to-output latency rules.
module tb_shift_out_reg;

  localparam int W = 32;

  logic         i_CLK = 1'b0;
  logic         i_RST;
  logic [W-1:0] i_DATA;
  logic         i_VALID;
  logic         i_STALL;
  logic         o_READY, o_D, o_EN, o_BUSY, o_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: t = 0 when idle, otherwise bits-sent position within the frame;
  // t in 1..W is a data cycle, t = W+1 is the done cycle.
  int           t = 0;
  logic         stalled = 1'b0;
  logic [W-1:0] word = '0;
  logic [W-1:0] rx = '0;
  int           n_frames = 0;

  shift_out_reg #(.DATA_WIDTH(W)) dut (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_DATA  (i_DATA),
    .i_VALID (i_VALID),
`ifdef SHIFT_OUT_STALL_EN
    .i_STALL (i_STALL),
`endif
    .o_READY (o_READY),
    .o_D     (o_D),
    .o_EN    (o_EN),
    .o_BUSY  (o_BUSY),
    .o_DONE  (o_DONE)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic valid, input logic [W-1:0] data,
                       input logic stall);
    logic exp_en, exp_d;
    i_RST   = rst;
    i_VALID = valid;
    i_DATA  = data;
    i_STALL = stall;
    @(posedge i_CLK);
    if (!rst) begin
      t = 0;
      stalled = 1'b0;
    end else if (t == 0) begin
      if (valid) begin
        word = data;
        t = 1;
      end
`ifdef SHIFT_OUT_STALL_EN
    end else if (t <= W && stall) begin
      stalled = 1'b1;
`endif
    end else if (t == W + 1) begin
      t = 0;
    end else begin
      stalled = 1'b0;
      t = t + 1;
    end
    @(negedge i_CLK);
    exp_en = (t >= 1) && (t <= W) && !stalled;
    exp_d  = (t >= 1 && t <= W) ? word[W-t] : 1'b0;
    check("ready", 64'(o_READY), 64'(t == 0));
    check("busy",  64'(o_BUSY),  64'(t != 0));
    check("en",    64'(o_EN),    64'(exp_en));
    check("d",     64'(o_D),     64'(exp_d));
    check("done",  64'(o_DONE),  64'(t == W + 1));
    if (!rst) rx = '0;
    else if (o_EN) rx = {rx[W-2:0], o_D};
    if (t == W + 1) begin
      check("rx_word", 64'(rx), 64'(word));
      n_frames++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, $urandom, 1'b0);
  endtask

  initial begin
    i_RST = 1'b0; i_VALID = 1'b0; i_DATA = '0; i_STALL = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, '1, 1'b0);

    // Single word 100.
    cycle(1'b1, 1'b1, 32'd100, 1'b0);
    idle(W + 3);

    // Back-to-back with valid held high; new data presented each cycle.
    cycle(1'b1, 1'b1, 32'h0000_0000, 1'b0);
    for (int i = 0; i < W + 1; i++) cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < W + 2; i++) cycle(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    idle(W + 3);

    // Mid-frame valid pulse with a different word is ignored.
    cycle(1'b1, 1'b1, 32'd10498, 1'b0);
    idle(8);
    cycle(1'b1, 1'b1, 32'd256, 1'b0);
    idle(W);

    // Reset at bit 10, then a fresh frame.
    cycle(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
    idle(10);
    cycle(1'b0, 1'b0, '0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b1, 32'd100, 1'b0);
    idle(W + 3);

    // Long idle.
    idle(50);

`ifdef SHIFT_OUT_STALL_EN
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(15);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    idle(W + 3);
`endif

    // Randomized traffic including all-zero/all-one words and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] dat;
      int sel;
      sel = $urandom_range(0, 9);
      dat = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0), dat,
            ($urandom_range(0, 3) == 0));
    end
    idle(W + 3);

    check("frames_seen", 64'(n_frames > 10), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
